// File: rtl/clk_divider_bank.sv
// Bank of NUM_CH independent clock-enable generators with runtime divisor/mode,
// shadowed configuration applied at each channel's wrap (or at once while idle).
module clk_divider_bank #(
    parameter int NUM_CH      = 4,
    parameter int DIV_WIDTH   = 32,
    parameter int DEFAULT_DIV = 125_000,
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CH-1:0]    en,
    input  logic                 sync_clr,
    input  logic                 cfg_we,
    input  logic [CH_W-1:0]      cfg_ch,
    input  logic [DIV_WIDTH-1:0] cfg_div,
    input  logic                 cfg_mode,
    output logic                 cfg_ack,
    output logic                 cfg_err,
    output logic [NUM_CH-1:0]    tick,
    output logic [NUM_CH-1:0]    wave
);

    localparam logic [DIV_WIDTH-1:0] DEF_DIV  = DIV_WIDTH'(DEFAULT_DIV);
    localparam logic [DIV_WIDTH-1:0] ONE      = DIV_WIDTH'(1);
    localparam logic [CH_W:0]        CH_LIMIT = (CH_W + 1)'(NUM_CH);

    logic [DIV_WIDTH-1:0] cnt     [NUM_CH];
    logic [DIV_WIDTH-1:0] act_div [NUM_CH];
    logic [DIV_WIDTH-1:0] sh_div  [NUM_CH];
    logic [DIV_WIDTH-1:0] d_eff   [NUM_CH];
    logic [DIV_WIDTH-1:0] ld_div  [NUM_CH];
    logic [NUM_CH-1:0]    act_mode;
    logic [NUM_CH-1:0]    sh_mode;
    logic [NUM_CH-1:0]    ld_mode;
    logic [NUM_CH-1:0]    wrap;
    logic [NUM_CH-1:0]    wr_hit;
    logic                 cfg_ok;
    logic [DIV_WIDTH-1:0] wr_div;

    // ld_* is what the shadow will hold after this cycle, so a write landing on
    // a wrap goes straight into the active registers.
    always_comb begin
        cfg_ok = ({1'b0, cfg_ch} < CH_LIMIT);
        wr_div = (cfg_div == '0) ? ONE : cfg_div;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            d_eff[i]   = (act_div[i] == '0) ? ONE : act_div[i];
            wrap[i]    = en[i] && (cnt[i] == d_eff[i] - ONE);
            wr_hit[i]  = cfg_we && cfg_ok && (cfg_ch == CH_W'(i));
            ld_div[i]  = wr_hit[i] ? wr_div : sh_div[i];
            ld_mode[i] = wr_hit[i] ? cfg_mode : sh_mode[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_ack  <= 1'b0;
            cfg_err  <= 1'b0;
            tick     <= '0;
            wave     <= '0;
            act_mode <= '0;
            sh_mode  <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cnt[i]     <= '0;
                act_div[i] <= DEF_DIV;
                sh_div[i]  <= DEF_DIV;
            end
        end else begin
            cfg_ack <= cfg_we && cfg_ok;
            cfg_err <= cfg_we && !cfg_ok;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (wr_hit[i]) begin
                    sh_div[i]  <= wr_div;
                    sh_mode[i] <= cfg_mode;
                end
                if (sync_clr || (wr_hit[i] && !en[i])) begin
                    cnt[i]      <= '0;
                    tick[i]     <= 1'b0;
                    wave[i]     <= 1'b0;
                    act_div[i]  <= ld_div[i];
                    act_mode[i] <= ld_mode[i];
                end else if (wrap[i]) begin
                    cnt[i]      <= '0;
                    tick[i]     <= 1'b1;
                    act_div[i]  <= ld_div[i];
                    act_mode[i] <= ld_mode[i];
                    // Leaving square mode parks the output low.
                    if (!ld_mode[i])
                        wave[i] <= 1'b0;
                    else if (act_mode[i])
                        wave[i] <= ~wave[i];
                end else if (en[i]) begin
                    cnt[i]  <= cnt[i] + ONE;
                    tick[i] <= 1'b0;
                end else begin
                    tick[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_divider_bank.sv
// Self-checking bench for clk_divider_bank: directed vector table, corner
// sequences, and randomized traffic against a countdown reference model.
module tb_clk_divider_bank;

    localparam int NCH  = 3;
    localparam int DW   = 8;
    localparam int DEFD = 4;
    localparam int NV   = 33;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [NCH-1:0] en = '0;
    logic           sync_clr = 1'b0;
    logic           cfg_we = 1'b0;
    logic [1:0]     cfg_ch = '0;
    logic [DW-1:0]  cfg_div = '0;
    logic           cfg_mode = 1'b0;
    logic           cfg_ack, cfg_err;
    logic [NCH-1:0] tick, wave;

    clk_divider_bank #(.NUM_CH(NCH), .DIV_WIDTH(DW), .DEFAULT_DIV(DEFD)) dut (
        .clk(clk), .rst(rst), .en(en), .sync_clr(sync_clr),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_mode(cfg_mode),
        .cfg_ack(cfg_ack), .cfg_err(cfg_err), .tick(tick), .wave(wave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: each channel counts down the edges left until its next tick.
    int       m_per [NCH];
    int       m_sh  [NCH];
    int       m_left[NCH];
    bit       m_mode[NCH];
    bit       m_shm [NCH];
    bit       m_lvl [NCH];
    bit       m_ack, m_err;
    bit [NCH-1:0] m_tick;
    bit       use_model = 1'b0;

    function automatic void model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_per[i] = DEFD; m_sh[i] = DEFD; m_left[i] = DEFD;
            m_mode[i] = 0; m_shm[i] = 0; m_lvl[i] = 0;
        end
        m_ack = 0; m_err = 0; m_tick = '0;
    endfunction

    function automatic void model_step();
        bit valid;
        int nd;
        valid = cfg_we && (int'(cfg_ch) < NCH);
        nd = (cfg_div == 0) ? 1 : int'(cfg_div);
        m_ack = valid;
        m_err = cfg_we && !valid;
        for (int i = 0; i < NCH; i++) begin
            bit hit;
            hit = valid && (int'(cfg_ch) == i);
            m_tick[i] = 0;
            if (hit) begin m_sh[i] = nd; m_shm[i] = cfg_mode; end
            if (sync_clr || (hit && !en[i])) begin
                m_per[i] = m_sh[i]; m_mode[i] = m_shm[i];
                m_left[i] = m_per[i]; m_lvl[i] = 0;
            end else if (en[i]) begin
                m_left[i]--;
                if (m_left[i] == 0) begin
                    m_tick[i] = 1;
                    if (!m_shm[i]) m_lvl[i] = 0;
                    else if (m_mode[i]) m_lvl[i] = !m_lvl[i];
                    m_per[i] = m_sh[i]; m_mode[i] = m_shm[i];
                    m_left[i] = m_per[i];
                end
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        if (use_model) model_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; en = '0; sync_clr = 0; cfg_we = 0;
        cfg_ch = '0; cfg_div = '0; cfg_mode = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [2:0] en; logic sclr; logic we; logic [1:0] ch; logic [7:0] div; logic mode;
        logic [2:0] etick; logic [2:0] ewave; logic eack; logic eerr;
    } vec_t;

    vec_t vecs[NV];

    function automatic vec_t mk(logic [2:0] e, logic we, logic [1:0] ch, logic [7:0] d, logic m,
                                logic [2:0] et, logic [2:0] ew, logic ea, logic ee);
        vec_t v;
        v.en = e; v.sclr = 0; v.we = we; v.ch = ch; v.div = d; v.mode = m;
        v.etick = et; v.ewave = ew; v.eack = ea; v.eerr = ee;
        return v;
    endfunction

    initial begin
        // Edges 1..12: default divisor 4 on all channels.
        for (int k = 1; k <= 12; k++)
            vecs[k-1] = mk(3'b111, 0, 2'd0, 8'd0, 0, (k % 4 == 0) ? 3'b111 : 3'b000, 3'b000, 0, 0);
        vecs[12] = mk(3'b101, 1, 2'd1, 8'd3, 1, 3'b000, 3'b000, 1, 0);
        vecs[13] = mk(3'b111, 0, 2'd0, 8'd0, 0, 3'b000, 3'b000, 0, 0);
        vecs[14] = mk(3'b111, 0, 2'd0, 8'd0, 0, 3'b000, 3'b000, 0, 0);
        vecs[15] = mk(3'b111, 0, 2'd0, 8'd0, 0, 3'b111, 3'b010, 0, 0);
        vecs[16] = mk(3'b111, 0, 2'd0, 8'd0, 0, 3'b000, 3'b010, 0, 0);
        vecs[17] = mk(3'b111, 0, 2'd0, 8'd0, 0, 3'b000, 3'b010, 0, 0);
        vecs[18] = mk(3'b111, 0, 2'd0, 8'd0, 0, 3'b010, 3'b000, 0, 0);
        vecs[19] = mk(3'b111, 0, 2'd0, 8'd0, 0, 3'b101, 3'b000, 0, 0);
        vecs[20] = mk(3'b111, 0, 2'd0, 8'd0, 0, 3'b000, 3'b000, 0, 0);
        vecs[21] = mk(3'b111, 0, 2'd0, 8'd0, 0, 3'b010, 3'b010, 0, 0);
        vecs[22] = mk(3'b111, 0, 2'd0, 8'd0, 0, 3'b000, 3'b010, 0, 0);
        vecs[23] = mk(3'b111, 0, 2'd0, 8'd0, 0, 3'b101, 3'b010, 0, 0);
        vecs[24] = mk(3'b111, 0, 2'd0, 8'd0, 0, 3'b010, 3'b000, 0, 0);
        vecs[25] = mk(3'b111, 1, 2'd3, 8'd7, 0, 3'b000, 3'b000, 0, 1);
        vecs[26] = mk(3'b111, 0, 2'd0, 8'd0, 0, 3'b000, 3'b000, 0, 0);
        vecs[27] = mk(3'b111, 0, 2'd0, 8'd0, 0, 3'b111, 3'b010, 0, 0);
        vecs[28] = mk(3'b011, 1, 2'd2, 8'd0, 0, 3'b000, 3'b010, 1, 0);
        vecs[29] = mk(3'b111, 0, 2'd0, 8'd0, 0, 3'b100, 3'b010, 0, 0);
        vecs[30] = mk(3'b111, 0, 2'd0, 8'd0, 0, 3'b110, 3'b000, 0, 0);
        vecs[31] = mk(3'b111, 0, 2'd0, 8'd0, 0, 3'b101, 3'b000, 0, 0);
        vecs[32] = mk(3'b111, 0, 2'd0, 8'd0, 0, 3'b100, 3'b000, 0, 0);

        // Reset state
        do_reset();
        chk("reset_outputs", {26'd0, tick, wave}, 32'd0);
        chk("reset_cfg", {30'd0, cfg_ack, cfg_err}, 32'd0);

        // Vector table
        for (int k = 0; k < NV; k++) begin
            en = vecs[k].en; sync_clr = vecs[k].sclr; cfg_we = vecs[k].we;
            cfg_ch = vecs[k].ch; cfg_div = vecs[k].div; cfg_mode = vecs[k].mode;
            step();
            chk($sformatf("vec%0d_tick_wave", k + 1), {26'd0, tick, wave}, {26'd0, vecs[k].etick, vecs[k].ewave});
            chk($sformatf("vec%0d_ack_err", k + 1), {30'd0, cfg_ack, cfg_err}, {30'd0, vecs[k].eack, vecs[k].eerr});
        end

        // Divisor change mid-period takes effect only after the current period.
        do_reset();
        cfg_we = 1; cfg_ch = 2'd0; cfg_div = 8'd10; cfg_mode = 0;
        step();
        chk("d10_load_ack", {31'd0, cfg_ack}, 32'd1);
        cfg_we = 0; en = 3'b001;
        for (int k = 1; k <= 16; k++) begin
            if (k == 6) begin cfg_we = 1; cfg_div = 8'd2; end
            else cfg_we = 0;
            step();
            chk($sformatf("late_div_edge%0d", k), {31'd0, tick[0]}, {31'd0, (k >= 10 && k % 2 == 0)});
        end
        cfg_we = 0;

        // sync_clr in mid-period, with ch1 in square mode.
        do_reset();
        cfg_we = 1; cfg_ch = 2'd1; cfg_div = 8'd2; cfg_mode = 1;
        step();
        cfg_we = 0; en = 3'b111;
        step(); step(); step();
        chk("preclr_wave", {29'd0, wave}, 32'b010);
        sync_clr = 1;
        step();
        chk("sync_clr_out", {26'd0, tick, wave}, 32'd0);
        sync_clr = 0;
        for (int k = 1; k <= 4; k++) begin
            logic [2:0] et, ew;
            et = (k == 2) ? 3'b010 : (k == 4) ? 3'b111 : 3'b000;
            ew = (k == 2 || k == 3) ? 3'b010 : 3'b000;
            step();
            chk($sformatf("postclr_edge%0d", k), {26'd0, tick, wave}, {26'd0, et, ew});
        end

        // Asynchronous reset mid-count and mid-write.
        do_reset();
        en = 3'b111;
        repeat (4) step();
        chk("pre_arst_tick", {29'd0, tick}, 32'b111);
        #2 rst = 0;
        #1 chk("arst_count", {24'd0, tick, wave, cfg_ack, cfg_err}, 32'd0);
        @(negedge clk);
        rst = 1; en = 3'b000;
        cfg_we = 1; cfg_ch = 2'd0; cfg_div = 8'd9; cfg_mode = 1;
        step();
        chk("pre_arst_ack", {31'd0, cfg_ack}, 32'd1);
        #2 rst = 0;
        #1 chk("arst_write", {24'd0, tick, wave, cfg_ack, cfg_err}, 32'd0);
        @(negedge clk);
        rst = 1; cfg_we = 0; en = 3'b111;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("default_div_edge%0d", k), {31'd0, tick[0]}, {31'd0, (k == 4)});
        end

        // Randomized traffic against the reference model.
        do_reset();
        use_model = 1;
        for (int n = 0; n < 600; n++) begin
            en = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
            sync_clr = ($urandom_range(0, 40) == 0);
            cfg_we = ($urandom_range(0, 3) == 0);
            cfg_ch = 2'($urandom_range(0, 3));
            cfg_div = 8'($urandom_range(0, 6));
            cfg_mode = 1'($urandom);
            step();
            chk($sformatf("rand%0d", n), {24'd0, tick, wave, cfg_ack, cfg_err},
                {24'd0, m_tick, m_lvl[2], m_lvl[1], m_lvl[0], m_ack, m_err});
        end
        use_model = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
